// File: rtl/core_exec.sv
// Execute / register-file stage: 32x32 register file, single-cycle ALU ops,
// 32-iteration shift-add multiply and a registered bus read port.
module core_exec (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [4:0]  rd,
  input  logic [15:0] imm,
  input  logic        load,
  input  logic        write_enable,
  input  logic [3:0]  operation,
  output logic        ready,
  output logic        done,
  input  logic [4:0]  read_addr,
  output logic [31:0] read_data
);

  localparam logic [3:0] OP_LLI  = 4'h1;
  localparam logic [3:0] OP_LUI  = 4'h2;
  localparam logic [3:0] OP_ADD  = 4'h3;
  localparam logic [3:0] OP_SUB  = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_AND  = 4'h6;
  localparam logic [3:0] OP_OR   = 4'h7;
  localparam logic [3:0] OP_NOT  = 4'h8;
  localparam logic [3:0] OP_ROTL = 4'h9;
  localparam logic [3:0] OP_ROTR = 4'hA;
  localparam logic [3:0] OP_SHL  = 4'hB;
  localparam logic [3:0] OP_SHR  = 4'hC;
  localparam logic [3:0] OP_MUL  = 4'hD;

  logic [31:0] r_rf [32];
  logic        r_e_valid;
  logic [3:0]  r_e_op;
  logic [4:0]  r_e_rd;
  logic [31:0] r_e_a;
  logic [31:0] r_e_b;
  logic [15:0] r_e_imm;
  logic [4:0]  r_mul_cnt;
  logic [31:0] r_mul_acc;
  logic [31:0] r_read_data;

  logic        w_op_writes;
  logic        w_accept;
  logic        w_e_is_mul;
  logic        w_mul_last;
  logic        w_e_commit;
  logic [4:0]  w_amt;
  logic [5:0]  w_amt_inv;
  logic [31:0] w_mul_sum;
  logic [31:0] w_e_result;
  logic [4:0]  w_idx_a;
  logic [31:0] w_src_a;
  logic [31:0] w_src_b;
  logic        w_fwd_ok;

  assign w_op_writes = (operation >= OP_LLI) && (operation <= OP_MUL);
  assign w_e_is_mul  = r_e_valid && (r_e_op == OP_MUL);
  assign w_mul_last  = (r_mul_cnt == 5'd31);
  assign w_e_commit  = r_e_valid && (!w_e_is_mul || w_mul_last);
  assign ready       = !w_e_is_mul;
  assign done        = w_e_commit;
  assign w_accept    = write_enable && ready && w_op_writes;
  assign read_data   = r_read_data;

  assign w_amt     = r_e_imm[4:0];
  assign w_amt_inv = 6'd32 - {1'b0, w_amt};
  assign w_mul_sum = r_mul_acc + (r_e_b[0] ? r_e_a : 32'd0);

  // Result of the instruction currently held in E
  always_comb begin
    w_e_result = 32'd0;
    case (r_e_op)
      OP_LLI:  w_e_result = {r_e_a[31:16], r_e_imm};
      OP_LUI:  w_e_result = {r_e_imm, r_e_a[15:0]};
      OP_ADD:  w_e_result = r_e_a + r_e_b;
      OP_SUB:  w_e_result = r_e_a - r_e_b;
      OP_XOR:  w_e_result = r_e_a ^ r_e_b;
      OP_AND:  w_e_result = r_e_a & r_e_b;
      OP_OR:   w_e_result = r_e_a | r_e_b;
      OP_NOT:  w_e_result = ~r_e_a;
      // shifting by 32 yields zero, so amount 0 passes A through
      OP_ROTL: w_e_result = (r_e_a << w_amt) | (r_e_a >> w_amt_inv);
      OP_ROTR: w_e_result = (r_e_a >> w_amt) | (r_e_a << w_amt_inv);
      OP_SHL:  w_e_result = r_e_a << w_amt;
      OP_SHR:  w_e_result = r_e_a >> w_amt;
      OP_MUL:  w_e_result = w_mul_sum;
      default: w_e_result = 32'd0;
    endcase
  end

  // Operand fetch with forwarding from a single-cycle instruction in E
  always_comb begin
    w_idx_a  = load ? rd : rs1;
    w_fwd_ok = r_e_valid && !w_e_is_mul && (r_e_rd != 5'd0);
    if (w_fwd_ok && (r_e_rd == w_idx_a)) begin
      w_src_a = w_e_result;
    end else begin
      w_src_a = r_rf[w_idx_a];
    end
    if (w_fwd_ok && (r_e_rd == rs2)) begin
      w_src_b = w_e_result;
    end else begin
      w_src_b = r_rf[rs2];
    end
  end

  // Execute register and multiply iteration state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_e_valid <= 1'b0;
      r_e_op    <= 4'd0;
      r_e_rd    <= 5'd0;
      r_e_a     <= 32'd0;
      r_e_b     <= 32'd0;
      r_e_imm   <= 16'd0;
      r_mul_cnt <= 5'd0;
      r_mul_acc <= 32'd0;
    end else if (w_accept) begin
      r_e_valid <= 1'b1;
      r_e_op    <= operation;
      r_e_rd    <= rd;
      r_e_a     <= w_src_a;
      r_e_b     <= w_src_b;
      r_e_imm   <= imm;
      r_mul_cnt <= 5'd0;
      r_mul_acc <= 32'd0;
    end else if (w_e_is_mul && !w_mul_last) begin
      r_e_a     <= r_e_a << 1;
      r_e_b     <= r_e_b >> 1;
      r_mul_acc <= w_mul_sum;
      r_mul_cnt <= r_mul_cnt + 5'd1;
    end else begin
      r_e_valid <= 1'b0;
    end
  end

  // Register file writeback and registered bus read (read sees pre-write value)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) begin
        r_rf[i] <= 32'd0;
      end
      r_read_data <= 32'd0;
    end else begin
      if (w_e_commit && (r_e_rd != 5'd0)) begin
        r_rf[r_e_rd] <= w_e_result;
      end
      r_read_data <= r_rf[read_addr];
    end
  end

endmodule
